and4_sweep_ctrl: RTL

Self-test sequencer for the four-input AND gate datapath (e = a&b, f = c&d, g = e&f).
- Drives all 16 input combinations into the gate under test and waits a programmable settle time per vector.
- Samples e/f/g each vector, compares them against the expected values, and reports pass/fail, mismatch count and first failing vector.
- Sits beside the gate instance on the lab board; replaces manual switch toggling.

---
 rtl/and4_sweep_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/and4_sweep_ctrl.sv
// Self-test sequencer for the four-input AND gate datapath: sweeps all 16 input
// vectors, checks e/f/g and reports pass, mismatch count and first failing vector.
// Optional build macro AND4_SWEEP_STOP_ON_ERR_EN: stop at the first mismatch.
module and4_sweep_ctrl #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       e_i,
   input  logic       f_i,
   input  logic       g_i,
   output logic       a_o,
   output logic       b_o,
   output logic       c_o,
   output logic       d_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      FINISH
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t     state;
   logic [3:0] idx;
   logic [3:0] settle_cnt;
   logic       e_x;
   logic       f_x;
   logic       g_x;
   logic       mismatch;

   always_comb begin
      e_x      = idx[0] & idx[1];
      f_x      = idx[2] & idx[3];
      g_x      = e_x & f_x;
      mismatch = ({e_i, f_i, g_i} != {e_x, f_x, g_x});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         c_o        <= 1'b0;
         d_o        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_vec   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx                    <= '0;
                  settle_cnt             <= '0;
                  err_cnt                <= '0;
                  fail_vec               <= '0;
                  pass                   <= 1'b0;
                  {d_o, c_o, b_o, a_o}   <= '0;
                  busy                   <= 1'b1;
                  state                  <= SETTLE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + 5'd1;
                  if (err_cnt == 5'd0) begin
                     fail_vec <= idx;
                  end
               end
`ifdef AND4_SWEEP_STOP_ON_ERR_EN
               // Stopping leaves idx and a_o..d_o on the failing vector for probing.
               if (mismatch || idx == 4'd15) begin
`else
               if (idx == 4'd15) begin
`endif
                  busy  <= 1'b0;
                  state <= FINISH;
               end else begin
                  idx                  <= idx + 4'd1;
                  {d_o, c_o, b_o, a_o} <= idx + 4'd1;
                  settle_cnt           <= '0;
                  state                <= SETTLE;
               end
            end
            FINISH: begin
               done  <= 1'b1;
               pass  <= (err_cnt == 5'd0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
